hms_v2: RTL and testbench
=========================

Name: hms_v2

Overview:
- Digital wrist-watch timekeeping core: a 24-hour hours/minutes/seconds counter with RUN and STOP (set) modes.
- In STOP mode the user picks a field with next and adjusts it with inc/dec.
- Sits between debounced push-button pulses and a display driver; outputs are plain binary fields.

Parameters:
TICKS_PER_SEC, 1, clock cycles per one-second advance in RUN mode (1 means one second per clock, for simulation).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset (0 = reset, sampled on clk rising edge)
stop_run  input  1  button pulse; each rising edge toggles RUN/STOP
inc  input  1  button pulse; increments selected field (STOP only)
dec  input  1  button pulse; decrements selected field (STOP only)
next  input  1  button pulse; advances field selection (STOP only)
hours  output  5  0..23
minutes  output  6  0..59
seconds  output  6  0..59

Behaviour:
- Reset (rst=0 at a clk edge):
  - hours=minutes=seconds=0, prescaler=0.
  - mode=RUN, selected field=HOURS.
  - Edge-detect history registers cleared to 0.
  - Applies mid-operation with the same result.
- Button inputs are edge-detected: each input is registered every cycle; an event is input=1 and previous=0. A held-high input produces exactly one event. Event effects are visible on outputs after the same clk edge that samples the rising edge (one-edge latency).
- All events in a cycle are evaluated against the mode held at the start of that cycle.
- RUN mode:
  - Prescaler counts 0..TICKS_PER_SEC-1. At terminal count, seconds increments and the prescaler returns to 0.
  - Carry chain: seconds 59->0 increments minutes; minutes 59->0 increments hours; hours 23->0. 23:59:59 -> 00:00:00 in one edge.
  - inc, dec and next are ignored.
- STOP mode:
  - Time is frozen and the prescaler is held at 0.
  - next cycles the selection HOURS -> MINUTES -> SECONDS -> HOURS.
  - inc adds 1 to the selected field with wrap (hours 23->0, min/sec 59->0). No carry into other fields.
  - dec subtracts 1 with wrap (hours 0->23, min/sec 0->59). No borrow.
  - inc and dec events in the same cycle: no change.
- stop_run event: toggles mode.
  - On entering STOP, selection is forced to HOURS; a simultaneous next, inc or dec is ignored because the old mode was RUN.
  - On leaving STOP, a simultaneous next/inc/dec is applied first (old mode STOP). The RUN prescaler then starts from 0, so the first second advance occurs TICKS_PER_SEC edges later.
- Outputs are registered; fields never hold out-of-range values.

Decomposition:
- Shared package hms_pkg: field-select encoding (SEL_HOURS=0, SEL_MIN=1, SEL_SEC=2), mode encoding (RUN=0, STOP=1), constants MAX_HOURS=23, MAX_MIN_SEC=59.
- One natural sub-module: hms_wrap_counter (parameterised modulus; inputs inc, dec, carry-in; outputs value, carry-out), instantiated three times.
- Edge detection and mode/selection FSM stay in the top.

Test Plan:
- Reset then run, TICKS_PER_SEC=1: after 5 edges -> 00:00:05. After 61 total edges -> 00:01:01. Assert rst=0 mid-count -> 00:00:00 on the next edge.
- Rollover: set 23:59:58 via STOP edits, resume -> 23:59:59 after 1 second advance (with prescaler restarting at 0), then 00:00:00 on the next advance.
- STOP at 00:00:05, one inc -> 01:00:05. One next then two inc -> 01:02:05. One next then one dec -> 01:02:04. Time stays frozen for 20 cycles.
- Wrap in STOP: hours at 0, dec -> 23. Seconds at 59, inc -> 0 with minutes unchanged. 30 random-spaced inc on minutes starting at 0 -> 30. 30 dec -> 0.
- Simultaneous events: inc+dec in the same cycle -> no change. stop_run+next while RUN -> enters STOP with selection HOURS. next+inc while STOP -> next applied, inc applied to the old selection in the same edge. inc held high 5 cycles -> single increment.
- RUN ignores edits: inc/dec/next pulses while running -> time continues advancing by exactly 1 per second, fields unaltered otherwise.

Source files
------------

// File: rtl/hms_pkg.sv
// hms_v2 shared types: field select, mode encoding
// and field limits.
package hms_pkg;

  typedef enum logic [1:0] {
    SEL_HOURS = 2'd0,
    SEL_MIN   = 2'd1,
    SEL_SEC   = 2'd2
  } sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } mode_e;

  localparam int MAX_HOURS   = 23;
  localparam int MAX_MIN_SEC = 59;

  function automatic sel_e sel_next(input sel_e s);
    sel_e r;
    unique case (s)
      SEL_HOURS: r = SEL_MIN;
      SEL_MIN:   r = SEL_SEC;
      default:   r = SEL_HOURS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hms_wrap_counter.sv
// Modulo (MAX+1) up/down counter with carry-in/out;
// one instance per time field.
module hms_wrap_counter
  import hms_pkg::*;
#(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         cin_i,
  output logic [W-1:0] value_o,
  output logic         cout_o
);

  localparam logic [W-1:0] TOP = W'(MAX);

  logic [W-1:0] val_q, val_d;
  logic         up, dn;

  // inc and dec together cancel; carry-in only arrives in RUN
  assign up = cin_i | (inc_i & ~dec_i);
  assign dn = dec_i & ~inc_i & ~cin_i;

  always_comb begin
    val_d = val_q;
    if (up)
      val_d = (val_q == TOP) ? '0 : val_q + 1'b1;
    else if (dn)
      val_d = (val_q == '0) ? TOP : val_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) val_q <= '0;
    else      val_q <= val_d;
  end

  assign value_o = val_q;
  assign cout_o  = cin_i & (val_q == TOP);

endmodule

// File: rtl/hms_v2.sv
// 24h hours/minutes/seconds watch core with
// RUN and STOP (set) modes.
module hms_v2
  import hms_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop_run,
  input  logic       inc,
  input  logic       dec,
  input  logic       next,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds
);

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  logic [3:0]    btn_q;
  logic          ev_sr, ev_inc, ev_dec, ev_nxt;
  mode_e         mode_q, mode_d;
  sel_e          sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          ed_inc, ed_dec;
  logic          sec_cout, min_cout, hr_cout_unused;

  assign ev_sr  = stop_run & ~btn_q[0];
  assign ev_inc = inc      & ~btn_q[1];
  assign ev_dec = dec      & ~btn_q[2];
  assign ev_nxt = next     & ~btn_q[3];

  always_comb begin
    mode_d  = mode_q;
    sel_d   = sel_q;
    presc_d = '0;
    tick    = 1'b0;
    unique case (mode_q)
      RUN: begin
        tick    = (presc_q == PMAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (ev_sr) begin
          mode_d  = STOP;
          sel_d   = SEL_HOURS;
          presc_d = '0;
        end
      end
      STOP: begin
        if (ev_nxt) sel_d = sel_next(sel_q);
        if (ev_sr)  mode_d = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q   <= '0;
      mode_q  <= RUN;
      sel_q   <= SEL_HOURS;
      presc_q <= '0;
    end else begin
      btn_q   <= {next, dec, inc, stop_run};
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      presc_q <= presc_d;
    end
  end

  // edits act on the selection held before this edge
  assign ed_inc = (mode_q == STOP) & ev_inc;
  assign ed_dec = (mode_q == STOP) & ev_dec;

  hms_wrap_counter #(.MAX(MAX_MIN_SEC), .W(6)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (ed_inc & (sel_q == SEL_SEC)),
    .dec_i  (ed_dec & (sel_q == SEL_SEC)),
    .cin_i  (tick),
    .value_o(seconds),
    .cout_o (sec_cout)
  );

  hms_wrap_counter #(.MAX(MAX_MIN_SEC), .W(6)) u_min (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (ed_inc & (sel_q == SEL_MIN)),
    .dec_i  (ed_dec & (sel_q == SEL_MIN)),
    .cin_i  (sec_cout),
    .value_o(minutes),
    .cout_o (min_cout)
  );

  hms_wrap_counter #(.MAX(MAX_HOURS), .W(5)) u_hr (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (ed_inc & (sel_q == SEL_HOURS)),
    .dec_i  (ed_dec & (sel_q == SEL_HOURS)),
    .cin_i  (min_cout),
    .value_o(hours),
    .cout_o (hr_cout_unused)
  );

endmodule

// File: tb/tb_hms_v2.sv
// Randomized + directed bench for hms_v2 against a
// total-seconds reference model.
module tb_hms_v2;

  localparam int TPS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop_run = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       next = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;

  int checks = 0;
  int errors = 0;

  int t = 0;
  int p = 0;
  int msel = 0;
  bit mstop = 0;
  bit p_sr, p_in, p_de, p_nx;

  always #5 clk = ~clk;

  hms_v2 #(.TICKS_PER_SEC(TPS)) dut (
    .clk     (clk),
    .rst     (rst),
    .stop_run(stop_run),
    .inc     (inc),
    .dec     (dec),
    .next    (next),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit sr,
                       input bit in, input bit de,
                       input bit nx);
    bit e_sr, e_in, e_de, e_nx;
    int h, m, s, d;
    if (!r) begin
      t = 0; p = 0; msel = 0; mstop = 0;
      {p_sr, p_in, p_de, p_nx} = 4'b0;
      return;
    end
    e_sr = sr & !p_sr; e_in = in & !p_in;
    e_de = de & !p_de; e_nx = nx & !p_nx;
    if (!mstop) begin
      if (p == TPS - 1) begin
        t = (t + 1) % 86400; p = 0;
      end else p++;
      if (e_sr) begin mstop = 1; msel = 0; p = 0; end
    end else begin
      if (e_in != e_de) begin
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        d = e_in ? 1 : -1;
        case (msel)
          0: h = (h + d + 24) % 24;
          1: m = (m + d + 60) % 60;
          default: s = (s + d + 60) % 60;
        endcase
        t = h * 3600 + m * 60 + s;
      end
      if (e_nx) msel = (msel + 1) % 3;
      if (e_sr) begin mstop = 0; p = 0; end
    end
    {p_sr, p_in, p_de, p_nx} = {sr, in, de, nx};
  endtask

  task automatic step(input bit r, input bit sr,
                      input bit in, input bit de,
                      input bit nx);
    @(negedge clk);
    rst = r; stop_run = sr; inc = in; dec = de; next = nx;
    @(posedge clk);
    model(r, sr, in, de, nx);
    #1;
    chk("hours",   int'(hours),   t / 3600);
    chk("minutes", int'(minutes), (t / 60) % 60);
    chk("seconds", int'(seconds), t % 60);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic pulse(input bit sr, input bit in,
                       input bit de, input bit nx);
    step(1, sr, in, de, nx);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic hms_is(input string tag, input int h,
                        input int m, input int s);
    chk({tag, "_h"}, int'(hours), h);
    chk({tag, "_m"}, int'(minutes), m);
    chk({tag, "_s"}, int'(seconds), s);
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    hms_is("reset", 0, 0, 0);

    idle(5);
    hms_is("run5", 0, 0, 5);
    idle(56);
    hms_is("run61", 0, 1, 1);
    step(0, 0, 0, 0, 0);
    hms_is("midrst", 0, 0, 0);

    // stop at 00:00:05 and edit
    idle(4);
    step(1, 1, 0, 0, 0);
    hms_is("stop", 0, 0, 5);
    idle(1);
    pulse(0, 1, 0, 0);
    hms_is("inc_h", 1, 0, 5);
    pulse(0, 0, 0, 1);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    hms_is("inc_m", 1, 2, 5);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 1, 0);
    hms_is("dec_s", 1, 2, 4);
    idle(20);
    hms_is("frozen", 1, 2, 4);

    // set 23:59:58 and roll over
    step(0, 0, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    hms_is("h_wrap", 23, 0, 1);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) pulse(0, 0, 1, 0);
    hms_is("set", 23, 59, 58);
    step(1, 1, 0, 0, 0);
    hms_is("resume", 23, 59, 58);
    idle(1);
    hms_is("r59", 23, 59, 59);
    idle(1);
    hms_is("r00", 0, 0, 0);

    // minutes up/down with random spacing
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      pulse(0, 1, 0, 0);
      idle($urandom_range(0, 3));
    end
    chk("min30", int'(minutes), 30);
    for (int i = 0; i < 30; i++) begin
      pulse(0, 0, 1, 0);
      idle($urandom_range(0, 3));
    end
    chk("min0", int'(minutes), 0);

    // seconds 59 -> 0 without carry
    pulse(0, 0, 0, 1);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    hms_is("s59", 0, 0, 59);
    pulse(0, 1, 0, 0);
    hms_is("s_wrap", 0, 0, 0);

    // simultaneous events
    pulse(0, 1, 1, 0);
    hms_is("incdec", 0, 0, 0);
    pulse(0, 1, 0, 1);
    hms_is("nx_inc", 0, 0, 1);
    pulse(0, 1, 0, 0);
    hms_is("sel_h", 1, 0, 1);
    step(1, 0, 1, 0, 0);
    idle(0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    hms_is("held", 2, 0, 1);
    pulse(1, 0, 0, 0);
    idle(3);
    pulse(1, 0, 0, 1);
    pulse(0, 1, 0, 0);
    chk("sr_nx_h", int'(hours), 3);

    // random phase, including edits while running
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
